uart_rx_fifo: RTL and testbench

Receive-side elastic buffer that sits directly downstream of the UART receiver. It captures each one-cycle `rx_ready` pulse together with `data_out`, `frame_error` and `parity_error` into a FIFO. Downstream consumers (echo path, transmitter) drain it through a valid/ready handshake. It also provides overflow detection, optional discard of errored bytes, and a saturating drop counter.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_fifo_mem.sv | 26 ++
 rtl/uart_rx_fifo.sv | 133 +++++++++++++
 tb/tb_uart_rx_fifo.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receive-path types and widths
package uart_pkg;

   localparam int UART_DATA_W  = 8;
   localparam int UART_ENTRY_W = 10;

   typedef struct packed {
      logic                   parity_error;
      logic                   frame_error;
      logic [UART_DATA_W-1:0] data;
   } uart_rx_entry_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - FIFO storage array, sync write / async read, contents not reset
module uart_fifo_mem
   import uart_pkg::*;
#(
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic           clk,
   input  logic           wr_en,
   input  logic [AW-1:0]  wr_addr,
   input  uart_rx_entry_t wr_data,
   input  logic [AW-1:0]  rd_addr,
   output uart_rx_entry_t rd_data
);

   uart_rx_entry_t mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive elastic buffer with overflow flag, errored-byte discard and drop counter
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter  int DEPTH        = 16,
   parameter  bit DROP_ERRORED = 1'b0,
   parameter  int CNT_WIDTH    = 8,
   localparam int AW           = $clog2(DEPTH),
   localparam int PW           = AW + 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [UART_DATA_W-1:0] in_data,
   input  logic                   in_valid,
   input  logic                   in_frame_error,
   input  logic                   in_parity_error,
   output logic [UART_DATA_W-1:0] out_data,
   output logic                   out_frame_error,
   output logic                   out_parity_error,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [PW-1:0]          level,
   output logic                   full,
   output logic                   empty,
   output logic                   overflow,
   input  logic                   clear_overflow,
   output logic [CNT_WIDTH-1:0]   drop_count
);

   logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]        level_q, level_d;
   logic                 full_q, full_d;
   logic                 empty_q, empty_d;
   logic                 overflow_q, overflow_d;
   logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

   logic           has_error;
   logic           push_req;
   logic           pop;
   logic           push;
   logic           drop_full;
   logic           drop_err;
   uart_rx_entry_t wr_entry;
   uart_rx_entry_t rd_entry;

   assign has_error = in_frame_error | in_parity_error;
   assign push_req  = in_valid & ~(DROP_ERRORED & has_error);
   assign pop       = ~empty_q & out_ready;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign push      = push_req & (~full_q | pop);
   assign drop_full = push_req & full_q & ~pop;
   assign drop_err  = in_valid & DROP_ERRORED & has_error;

   assign wr_entry.parity_error = in_parity_error;
   assign wr_entry.frame_error  = in_frame_error;
   assign wr_entry.data         = in_data;

   uart_fifo_mem #(
      .DEPTH (DEPTH)
   ) u_mem (
      .clk     (clk),
      .wr_en   (push & ~rst),
      .wr_addr (wr_ptr_q[AW-1:0]),
      .wr_data (wr_entry),
      .rd_addr (rd_ptr_q[AW-1:0]),
      .rd_data (rd_entry)
   );

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;

      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      if (clear_overflow) begin
         overflow_d = 1'b0;
      end
      if (drop_full) begin
         overflow_d = 1'b1;
      end

      if ((drop_full | drop_err) && (drop_cnt_q != {CNT_WIDTH{1'b1}})) begin
         drop_cnt_d = drop_cnt_q + 1'b1;
      end

      // Flags follow the post-edge pointers; the wrap bit separates full from empty.
      level_d = wr_ptr_d - rd_ptr_d;
      empty_d = (wr_ptr_d == rd_ptr_d);
      full_d  = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) &&
                (wr_ptr_d[AW] != rd_ptr_d[AW]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Storage is never reset, so mask the head while nothing valid is held.
   assign out_data         = empty_q ? '0   : rd_entry.data;
   assign out_frame_error  = empty_q ? 1'b0 : rd_entry.frame_error;
   assign out_parity_error = empty_q ? 1'b0 : rd_entry.parity_error;
   assign out_valid        = ~empty_q;

   assign level      = level_q;
   assign full       = full_q;
   assign empty      = empty_q;
   assign overflow   = overflow_q;
   assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] in_data = '0;
   logic       in_valid = 1'b0;
   logic       in_fe = 1'b0;
   logic       in_pe = 1'b0;
   logic       out_ready = 1'b0;
   logic       clear_overflow = 1'b0;

   logic [7:0] a_data, b_data;
   logic       a_fe, a_pe, a_valid, a_full, a_empty, a_ovf;
   logic       b_fe, b_pe, b_valid, b_full, b_empty, b_ovf;
   logic [4:0] a_level, b_level;
   logic [7:0] a_drop, b_drop;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   uart_rx_fifo #(.DEPTH(16), .DROP_ERRORED(1'b0), .CNT_WIDTH(8)) u_dut_keep (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_frame_error(in_fe), .in_parity_error(in_pe),
      .out_data(a_data), .out_frame_error(a_fe), .out_parity_error(a_pe),
      .out_valid(a_valid), .out_ready(out_ready), .level(a_level),
      .full(a_full), .empty(a_empty), .overflow(a_ovf),
      .clear_overflow(clear_overflow), .drop_count(a_drop)
   );

   uart_rx_fifo #(.DEPTH(16), .DROP_ERRORED(1'b1), .CNT_WIDTH(8)) u_dut_drop (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_frame_error(in_fe), .in_parity_error(in_pe),
      .out_data(b_data), .out_frame_error(b_fe), .out_parity_error(b_pe),
      .out_valid(b_valid), .out_ready(out_ready), .level(b_level),
      .full(b_full), .empty(b_empty), .overflow(b_ovf),
      .clear_overflow(clear_overflow), .drop_count(b_drop)
   );

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      clear_overflow = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic push(input logic [7:0] d, input logic fe, input logic pe);
      in_data = d;
      in_fe = fe;
      in_pe = pe;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      in_fe = 1'b0;
      in_pe = 1'b0;
   endtask

   task automatic pop_expect(input string tag, input logic [7:0] exp);
      check({tag, "_valid"}, a_valid, 1);
      check({tag, "_data"}, a_data, exp);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      // 1: reset values, show-ahead latency, in-order drain
      do_reset();
      check("rst_level", a_level, 0);
      check("rst_empty", a_empty, 1);
      check("rst_full", a_full, 0);
      check("rst_valid", a_valid, 0);
      check("rst_ovf", a_ovf, 0);
      check("rst_drop", a_drop, 0);
      check("rst_data", a_data, 0);
      push(8'h41, 1'b0, 1'b0);
      check("t1_valid_lat", a_valid, 1);
      check("t1_head", a_data, 8'h41);
      check("t1_level1", a_level, 1);
      tick();
      push(8'h42, 1'b0, 1'b0);
      tick();
      push(8'h43, 1'b0, 1'b0);
      check("t1_level3", a_level, 3);
      check("t1_head_hold", a_data, 8'h41);
      pop_expect("t1_pop0", 8'h41);
      pop_expect("t1_pop1", 8'h42);
      pop_expect("t1_pop2", 8'h43);
      check("t1_empty", a_empty, 1);
      check("t1_valid_end", a_valid, 0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("t1_ready_noop", a_level, 0);

      // 2: fill past full, overflow and drop, drain in order
      do_reset();
      for (int i = 0; i < 16; i++) push(i[7:0], 1'b0, 1'b0);
      check("t2_full", a_full, 1);
      check("t2_level", a_level, 16);
      check("t2_ovf_pre", a_ovf, 0);
      push(8'h10, 1'b0, 1'b0);
      check("t2_ovf", a_ovf, 1);
      check("t2_drop", a_drop, 1);
      check("t2_level_hold", a_level, 16);
      for (int i = 0; i < 16; i++) pop_expect("t2_pop", i[7:0]);
      check("t2_empty", a_empty, 1);

      // 3: simultaneous push and pop while full
      do_reset();
      for (int i = 0; i < 16; i++) push(i[7:0], 1'b0, 1'b0);
      in_data = 8'hAA;
      in_valid = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      out_ready = 1'b0;
      check("t3_ovf", a_ovf, 0);
      check("t3_level", a_level, 16);
      check("t3_full", a_full, 1);
      check("t3_drop", a_drop, 0);
      for (int i = 1; i < 16; i++) pop_expect("t3_pop", i[7:0]);
      pop_expect("t3_last", 8'hAA);
      check("t3_empty", a_empty, 1);

      // 4: errored-byte discard vs keep
      do_reset();
      push(8'h55, 1'b0, 1'b1);
      push(8'h66, 1'b0, 1'b0);
      check("t4_b_level", b_level, 1);
      check("t4_b_data", b_data, 8'h66);
      check("t4_b_pe", b_pe, 0);
      check("t4_b_drop", b_drop, 1);
      check("t4_b_ovf", b_ovf, 0);
      check("t4_a_level", a_level, 2);
      check("t4_a_data", a_data, 8'h55);
      check("t4_a_pe", a_pe, 1);
      check("t4_a_drop", a_drop, 0);
      do_reset();
      push(8'h3C, 1'b1, 1'b0);
      check("t4_b_fe_drop", b_drop, 1);
      check("t4_b_fe_empty", b_empty, 1);
      check("t4_a_fe", a_fe, 1);

      // 5: clear vs set priority, drop counter saturation
      do_reset();
      for (int i = 0; i < 16; i++) push(i[7:0], 1'b0, 1'b0);
      push(8'hF0, 1'b0, 1'b0);
      check("t5_ovf_set", a_ovf, 1);
      clear_overflow = 1'b1;
      push(8'hF1, 1'b0, 1'b0);
      clear_overflow = 1'b0;
      check("t5_set_wins", a_ovf, 1);
      check("t5_drop2", a_drop, 2);
      clear_overflow = 1'b1;
      tick();
      clear_overflow = 1'b0;
      check("t5_cleared", a_ovf, 0);
      check("t5_drop_kept", a_drop, 2);
      in_valid = 1'b1;
      for (int i = 0; i < 252; i++) tick();
      check("t5_drop254", a_drop, 254);
      for (int i = 0; i < 46; i++) tick();
      in_valid = 1'b0;
      check("t5_drop_sat", a_drop, 255);
      check("t5_ovf_again", a_ovf, 1);

      // 6: reset mid-operation with a coincident write
      do_reset();
      for (int i = 0; i < 16; i++) push(i[7:0], 1'b0, 1'b0);
      push(8'hEE, 1'b0, 1'b0);
      out_ready = 1'b1;
      for (int i = 0; i < 11; i++) tick();
      out_ready = 1'b0;
      check("t6_pre_level", a_level, 5);
      check("t6_pre_drop", a_drop, 1);
      rst = 1'b1;
      in_data = 8'h77;
      in_valid = 1'b1;
      tick();
      rst = 1'b0;
      in_valid = 1'b0;
      check("t6_level", a_level, 0);
      check("t6_valid", a_valid, 0);
      check("t6_ovf", a_ovf, 0);
      check("t6_drop", a_drop, 0);
      tick();
      check("t6_not_stored", a_empty, 1);
      push(8'h12, 1'b0, 1'b0);
      check("t6_fresh_data", a_data, 8'h12);
      check("t6_fresh_level", a_level, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
